// File: rtl/fp_shift_scheduler.sv
// Round-robin shared 24-bit shifter for the FP add pipe: align (logical right) and normalize (logical left).
// Optional sticky output for right shifts is enabled by defining SHIFT_STICKY_EN.
module fp_shift_scheduler #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [SHW-1:0]   a_amt,
  input  logic             n_valid,
  output logic             n_ready,
  input  logic [WIDTH-1:0] n_data,
  input  logic [SHW-1:0]   n_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_sticky
);

  typedef enum logic {ID_ALIGN = 1'b0, ID_NORM = 1'b1} req_id_t;

  logic             s1_valid;
  req_id_t          s1_id;
  logic [WIDTH-1:0] s1_data;
  logic [SHW-1:0]   s1_amt;

  logic             s2_valid;
  req_id_t          s2_id;
  logic [WIDTH-1:0] s2_data;

  req_id_t          last;
  req_id_t          grant;
  logic             accept;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    s2_adv  = !s2_valid || res_ready;
    s1_adv  = !s1_valid || s2_adv;
    // On a tie the requester that did not win last time is granted.
    if (a_valid && n_valid) grant = (last == ID_ALIGN) ? ID_NORM : ID_ALIGN;
    else if (n_valid)       grant = ID_NORM;
    else                    grant = ID_ALIGN;
    accept  = !rst && s1_adv && (a_valid || n_valid);
    shifted = (s1_id == ID_NORM) ? (s1_data << s1_amt) : (s1_data >> s1_amt);
  end

  assign a_ready = accept && (grant == ID_ALIGN);
  assign n_ready = accept && (grant == ID_NORM);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= ID_ALIGN;
      s1_data  <= '0;
      s1_amt   <= '0;
      s2_valid <= 1'b0;
      s2_id    <= ID_ALIGN;
      s2_data  <= '0;
      last     <= ID_NORM;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id   <= s1_id;
          s2_data <= shifted;
        end
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_id   <= grant;
          s1_data <= (grant == ID_NORM) ? n_data : a_data;
          s1_amt  <= (grant == ID_NORM) ? n_amt : a_amt;
          last    <= grant;
        end
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_data  = s2_data;
  assign res_id    = s2_id;

`ifdef SHIFT_STICKY_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  logic s2_sticky;
  logic sticky_nxt;

  // Mask of bits dropped by the right shift; saturates to all ones once amt >= WIDTH.
  always_comb begin
    sticky_nxt = (s1_id == ID_ALIGN) && (|(s1_data & ~(ALL_ONES << s1_amt)));
  end

  always_ff @(posedge clk) begin
    if (rst)                      s2_sticky <= 1'b0;
    else if (s2_adv && s1_valid)  s2_sticky <= sticky_nxt;
  end

  assign res_sticky = s2_sticky;
`else
  assign res_sticky = 1'b0;
`endif

endmodule
